// File: rtl/portal_indication_mux.sv
// Multi-channel indication FIFO bank with host-selected dequeue, round-robin
// interrupt arbitration and a saturating drop counter.
module portal_indication_mux #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NUM_CH-1:0]          EN_ind,
  input  logic [NUM_CH*DATA_W-1:0]   ind_v,
  output logic [NUM_CH-1:0]          RDY_ind,
  input  logic [15:0]                messageSize_methodNumber,
  output logic [15:0]                messageSize_size,
  input  logic [$clog2(NUM_CH)-1:0]  deq_sel,
  output logic [DATA_W-1:0]          first,
  output logic                       RDY_deq,
  input  logic                       EN_deq,
  output logic [NUM_CH-1:0]          notEmpty,
  input  logic                       intr_enable,
  output logic                       intr_status,
  output logic [15:0]                intr_channel,
  output logic [15:0]                drop_count
);

  localparam int CW = $clog2(NUM_CH);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;

  logic [DATA_W-1:0] mem_q [NUM_CH][DEPTH];
  logic [AW-1:0]     wptr_q [NUM_CH];
  logic [AW-1:0]     wptr_d [NUM_CH];
  logic [AW-1:0]     rptr_q [NUM_CH];
  logic [AW-1:0]     rptr_d [NUM_CH];
  logic [NW-1:0]     count_q [NUM_CH];
  logic [NW-1:0]     count_d [NUM_CH];
  logic [NUM_CH-1:0] full, do_enq, do_deq_c, drop, ne_d;
  logic [CW-1:0]     rr_q, rr_d;
  logic [CW-1:0]     sel_idx;
  logic              sel_valid;
  logic              do_deq;
  logic [4:0]        n_drop;
  logic [16:0]       drop_sum;
  logic [15:0]       intr_channel_d, drop_count_d;
  logic              intr_status_d;
  int                arb_j;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      full[c]     = (count_q[c] == NW'(DEPTH));
      RDY_ind[c]  = ~full[c];
      notEmpty[c] = (count_q[c] != '0);
    end
  end

  assign RDY_deq = (32'(deq_sel) < NUM_CH) ? notEmpty[deq_sel] : 1'b0;
  assign do_deq  = EN_deq & RDY_deq;
  assign first   = mem_q[deq_sel][rptr_q[deq_sel]];

  assign messageSize_size = (32'(messageSize_methodNumber) < NUM_CH) ? 16'(DATA_W) : 16'd0;

  always_comb begin
    n_drop = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      do_enq[c]   = EN_ind[c] & ~full[c];
      drop[c]     = EN_ind[c] & full[c];
      do_deq_c[c] = do_deq && (deq_sel == CW'(c));
      wptr_d[c]   = do_enq[c]   ? wptr_q[c] + AW'(1) : wptr_q[c];
      rptr_d[c]   = do_deq_c[c] ? rptr_q[c] + AW'(1) : rptr_q[c];
      count_d[c]  = count_q[c] + NW'(do_enq[c]) - NW'(do_deq_c[c]);
      ne_d[c]     = (count_d[c] != '0);
      n_drop      = n_drop + 5'(drop[c]);
    end
    drop_sum     = {1'b0, drop_count} + 17'(n_drop);
    drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // Search starts just after the channel most recently dequeued, using next-cycle occupancy.
  always_comb begin
    rr_d      = do_deq ? deq_sel : rr_q;
    sel_valid = 1'b0;
    sel_idx   = '0;
    arb_j     = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      arb_j = int'(rr_d) + i;
      if (arb_j >= NUM_CH) arb_j = arb_j - NUM_CH;
      if (!sel_valid && ne_d[arb_j]) begin
        sel_valid = 1'b1;
        sel_idx   = CW'(arb_j);
      end
    end
    intr_channel_d = sel_valid ? 16'(sel_idx) + 16'd1 : 16'd0;
    intr_status_d  = (intr_channel_d != 16'd0) && intr_enable;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wptr_q[c]  <= '0;
        rptr_q[c]  <= '0;
        count_q[c] <= '0;
      end
      rr_q         <= CW'(NUM_CH - 1);
      intr_channel <= '0;
      intr_status  <= 1'b0;
      drop_count   <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        wptr_q[c]  <= wptr_d[c];
        rptr_q[c]  <= rptr_d[c];
        count_q[c] <= count_d[c];
      end
      rr_q         <= rr_d;
      intr_channel <= intr_channel_d;
      intr_status  <= intr_status_d;
      drop_count   <= drop_count_d;
    end
  end

  // Storage is deliberately left out of reset; occupancy counts make stale words invisible.
  always_ff @(posedge CLK) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (do_enq[c]) mem_q[c][wptr_q[c]] <= ind_v[c*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_portal_indication_mux.sv
// Directed bench for portal_indication_mux: stimulus pushes expected dequeued
// words into a scoreboard, a negedge monitor pops and compares them.
module tb_portal_indication_mux;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [3:0]   EN_ind = '0;
  logic [127:0] ind_v = '0;
  logic [3:0]   RDY_ind;
  logic [15:0]  messageSize_methodNumber = '0;
  logic [15:0]  messageSize_size;
  logic [1:0]   deq_sel = '0;
  logic [31:0]  first;
  logic         RDY_deq;
  logic         EN_deq = 1'b0;
  logic [3:0]   notEmpty;
  logic         intr_enable = 1'b1;
  logic         intr_status;
  logic [15:0]  intr_channel;
  logic [15:0]  drop_count;

  portal_indication_mux #(.NUM_CH(4), .DATA_W(32), .DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .EN_ind(EN_ind), .ind_v(ind_v), .RDY_ind(RDY_ind),
    .messageSize_methodNumber(messageSize_methodNumber), .messageSize_size(messageSize_size),
    .deq_sel(deq_sel), .first(first), .RDY_deq(RDY_deq), .EN_deq(EN_deq),
    .notEmpty(notEmpty), .intr_enable(intr_enable), .intr_status(intr_status),
    .intr_channel(intr_channel), .drop_count(drop_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  ch;
    logic [31:0] data;
  } sb_t;

  sb_t sb[$];
  int  checks   = 0;
  int  failures = 0;
  bit  done     = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [1:0] ch, input logic [31:0] data);
    sb_t e;
    e.ch   = ch;
    e.data = data;
    sb.push_back(e);
  endtask

  // Monitor: every accepted dequeue must match the oldest expected word.
  initial begin
    sb_t e;
    forever begin
      @(negedge CLK);
      if (!RST && EN_deq && RDY_deq) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL deq_unexpected: got ch%0d data %h expected no dequeue", deq_sel, first);
        end else begin
          e = sb.pop_front();
          if (first !== e.data || deq_sel !== e.ch) begin
            failures++;
            $display("FAIL deq_word: got ch%0d data %h expected ch%0d data %h",
                     deq_sel, first, e.ch, e.data);
          end
        end
      end
    end
  end

  initial begin
    int rr_exp[4];
    rr_exp = '{1, 2, 4, 0};

    // Reset values and message size lookup
    #2;
    chk("rst_notEmpty", 32'(notEmpty), 32'h0);
    chk("rst_RDY_ind", 32'(RDY_ind), 32'hF);
    chk("rst_intr_channel", 32'(intr_channel), 32'h0);
    chk("rst_intr_status", 32'(intr_status), 32'h0);
    chk("rst_drop_count", 32'(drop_count), 32'h0);
    chk("rst_RDY_deq", 32'(RDY_deq), 32'h0);
    messageSize_methodNumber = 16'd3;
    #1 chk("size_m3", 32'(messageSize_size), 32'd32);
    messageSize_methodNumber = 16'd4;
    #1 chk("size_m4", 32'(messageSize_size), 32'd0);
    tick();
    RST = 1'b0;

    // Round robin: channels 0,1,3 hold one word each, rr starts at 3
    EN_ind = 4'b1011;
    ind_v  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    tick();
    EN_ind = '0;
    chk("rr_notEmpty", 32'(notEmpty), 32'hB);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr_intr_channel_%0d", k), 32'(intr_channel), 32'(rr_exp[k]));
      if (rr_exp[k] != 0) begin
        deq_sel = 2'(rr_exp[k] - 1);
        push(2'(rr_exp[k] - 1), 32'hA0 + 32'(rr_exp[k] - 1));
        EN_deq = 1'b1;
        tick();
        EN_deq = 1'b0;
      end
    end

    // Single word on channel 2
    ind_v = '0;
    ind_v[2*32 +: 32] = 32'hDEADBEEF;
    EN_ind = 4'b0100;
    tick();
    EN_ind = '0;
    chk("sw_notEmpty", 32'(notEmpty), 32'h4);
    chk("sw_intr_channel", 32'(intr_channel), 32'd3);
    chk("sw_intr_status", 32'(intr_status), 32'd1);
    deq_sel = 2'd2;
    #1 chk("sw_first", first, 32'hDEADBEEF);
    chk("sw_RDY_deq", 32'(RDY_deq), 32'd1);
    push(2'd2, 32'hDEADBEEF);
    EN_deq = 1'b1;
    tick();
    EN_deq = 1'b0;
    chk("sw_intr_channel_after", 32'(intr_channel), 32'd0);
    chk("sw_intr_status_after", 32'(intr_status), 32'd0);
    chk("sw_notEmpty_after", 32'(notEmpty), 32'h0);

    // Full / drop on channel 0
    for (int i = 0; i < 5; i++) begin
      ind_v = '0;
      ind_v[31:0] = 32'h11 + 32'(i);
      EN_ind = 4'b0001;
      tick();
      if (i == 3) chk("full_RDY_ind0", 32'(RDY_ind[0]), 32'd0);
    end
    EN_ind = '0;
    chk("full_drop_count", 32'(drop_count), 32'd1);
    chk("full_intr_channel", 32'(intr_channel), 32'd1);
    deq_sel = 2'd0;
    for (int i = 0; i < 4; i++) begin
      push(2'd0, 32'h11 + 32'(i));
      EN_deq = 1'b1;
      tick();
    end
    EN_deq = 1'b0;
    chk("full_notEmpty_drained", 32'(notEmpty), 32'h0);
    chk("full_RDY_ind_drained", 32'(RDY_ind), 32'hF);

    // Fill channels 0 and 1 together, then a double drop (rr is now 0)
    for (int i = 0; i < 5; i++) begin
      ind_v = '0;
      ind_v[31:0]  = 32'h200 + 32'(i);
      ind_v[63:32] = 32'h300 + 32'(i);
      EN_ind = 4'b0011;
      tick();
    end
    EN_ind = '0;
    chk("dd_drop_count", 32'(drop_count), 32'd3);
    chk("dd_RDY_ind", 32'(RDY_ind), 32'hC);
    chk("dd_intr_channel", 32'(intr_channel), 32'd2);
    deq_sel = 2'd0;
    for (int i = 0; i < 4; i++) begin
      push(2'd0, 32'h200 + 32'(i));
      EN_deq = 1'b1;
      tick();
    end
    EN_deq = 1'b0;
    chk("dd_intr_channel_ch1", 32'(intr_channel), 32'd2);
    deq_sel = 2'd1;
    for (int i = 0; i < 4; i++) begin
      push(2'd1, 32'h300 + 32'(i));
      EN_deq = 1'b1;
      tick();
    end
    EN_deq = 1'b0;
    chk("dd_intr_channel_empty", 32'(intr_channel), 32'd0);

    // Dequeue of an empty channel is ignored
    deq_sel = 2'd2;
    EN_deq  = 1'b1;
    #1 chk("empty_RDY_deq", 32'(RDY_deq), 32'd0);
    tick();
    EN_deq = 1'b0;
    chk("empty_notEmpty", 32'(notEmpty), 32'h0);

    // Concurrent enqueue/dequeue on channel 1 with interrupts gated
    intr_enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ind_v = '0;
      ind_v[63:32] = 32'h41 + 32'(i);
      EN_ind = 4'b0010;
      tick();
    end
    chk("cc_intr_channel", 32'(intr_channel), 32'd2);
    chk("cc_intr_status", 32'(intr_status), 32'd0);
    ind_v = '0;
    ind_v[63:32] = 32'h43;
    EN_ind  = 4'b0010;
    deq_sel = 2'd1;
    push(2'd1, 32'h41);
    EN_deq = 1'b1;
    tick();
    EN_ind = '0;
    EN_deq = 1'b0;
    chk("cc_notEmpty", 32'(notEmpty), 32'h2);
    chk("cc_RDY_ind", 32'(RDY_ind), 32'hF);
    chk("cc_intr_channel_after", 32'(intr_channel), 32'd2);
    chk("cc_intr_status_after", 32'(intr_status), 32'd0);
    for (int i = 0; i < 2; i++) begin
      push(2'd1, 32'h42 + 32'(i));
      EN_deq = 1'b1;
      tick();
    end
    EN_deq = 1'b0;
    chk("cc_notEmpty_drained", 32'(notEmpty), 32'h0);

    // Asynchronous reset with three words queued
    intr_enable = 1'b1;
    ind_v  = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    EN_ind = 4'b1101;
    tick();
    EN_ind = '0;
    chk("ar_notEmpty_before", 32'(notEmpty), 32'hD);
    chk("ar_intr_status_before", 32'(intr_status), 32'd1);
    #2 RST = 1'b1;
    #1;
    chk("ar_notEmpty", 32'(notEmpty), 32'h0);
    chk("ar_RDY_ind", 32'(RDY_ind), 32'hF);
    chk("ar_intr_channel", 32'(intr_channel), 32'd0);
    chk("ar_intr_status", 32'(intr_status), 32'd0);
    chk("ar_drop_count", 32'(drop_count), 32'd0);
    chk("ar_RDY_deq", 32'(RDY_deq), 32'd0);
    tick();
    RST = 1'b0;
    tick();
    tick();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    done = 1'b1;
    $finish;
  end

  initial begin
    #20000;
    if (!done) begin
      $display("FAIL timeout: got no end of test expected finish before 20000");
      $fatal(1, "timeout");
    end
  end

endmodule

// File: doc/portal_indication_mux.md
PORTAL_INDICATION_MUX -- requirements
Module: portal_indication_mux

Interface
REQ-001 Parameter NUM_CH, default 4: number of indication method channels, range 2..16.
REQ-002 Parameter DATA_W, default 32: indication word width in bits.
REQ-003 Parameter DEPTH, default 4: per-channel FIFO depth in words, power of two, at least 2.
REQ-004 Ports, one per line, SHALL be: name, direction, width, meaning.
- CLK  in  1  sole clock; all state on rising edge
- RST  in  1  asynchronous, active-high reset
- EN_ind  in  NUM_CH  per-channel enqueue strobe
- ind_v  in  NUM_CH*DATA_W  per-channel data; channel c occupies bits [c*DATA_W +: DATA_W]
- RDY_ind  out  NUM_CH  channel c FIFO not full
- messageSize_methodNumber  in  16  method number to query
- messageSize_size  out  16  message size in bits for the queried method
- deq_sel  in  clog2(NUM_CH)  host-selected channel
- first  out  DATA_W  head word of channel deq_sel
- RDY_deq  out  1  channel deq_sel not empty
- EN_deq  in  1  dequeue head of channel deq_sel
- notEmpty  out  NUM_CH  per-channel not-empty vector
- intr_enable  in  1  level-sensitive interrupt gate
- intr_status  out  1  registered interrupt request
- intr_channel  out  16  registered: 1 + pending channel index, 0 = none
- drop_count  out  16  saturating count of dropped enqueues

Function
REQ-005 Each channel SHALL be an independent FIFO of DEPTH words with wrap-around read and write pointers and a clog2(DEPTH)+1-bit occupancy count.
REQ-006 RDY_ind[c] SHALL equal (count[c] != DEPTH); a dequeue in the same cycle does not raise it.
REQ-007 EN_ind[c]=1 with RDY_ind[c]=1 SHALL write ind_v slice c at wptr[c]; the word is visible on first and notEmpty on the next cycle (latency 1).
REQ-008 EN_ind[c]=1 with RDY_ind[c]=0 SHALL discard the word, leave the FIFO unchanged and increment drop_count, saturating at 0xFFFF; simultaneous drops on k channels add k, saturating.
REQ-009 notEmpty[c] SHALL equal (count[c] != 0); RDY_deq SHALL equal notEmpty[deq_sel]; first SHALL combinationally present the head of channel deq_sel, value undefined when empty.
REQ-010 EN_deq=1 with RDY_deq=1 SHALL advance rptr[deq_sel]; EN_deq while RDY_deq=0 SHALL be ignored.
REQ-011 Enqueue and dequeue on the same non-empty, non-full channel in one cycle SHALL both occur and leave count unchanged.
REQ-012 messageSize_size SHALL combinationally return DATA_W when messageSize_methodNumber < NUM_CH, else 0.
REQ-013 A round-robin pointer rr SHALL hold the last channel dequeued, reset value NUM_CH-1, updated to deq_sel on every accepted dequeue.
REQ-014 Each cycle the arbiter SHALL select the first non-empty channel, by next-state notEmpty, searching rr+1, rr+2, ... modulo NUM_CH.
REQ-015 intr_channel SHALL register 1 + the selected index, or 0 if no channel will be non-empty; latency one cycle after the enqueue or dequeue that changes it.
REQ-016 intr_status SHALL register (intr_channel_next != 0) AND intr_enable; intr_channel is updated regardless of intr_enable.

Reset
REQ-017 While RST=1, asynchronously: all pointers and counts 0, rr=NUM_CH-1, intr_status=0, intr_channel=0, drop_count=0, notEmpty=0, RDY_ind all ones; FIFO storage is not reset.
REQ-018 Reset asserted mid-transfer SHALL discard all queued words; enqueues and dequeues in the cycle RST deasserts are ignored, and the first accepted edge is the one after deassertion.

Verification
REQ-019 Single word: NUM_CH=4; enqueue 0xDEADBEEF on channel 2 -> next cycle notEmpty=0100, intr_channel=3, intr_status=1; deq_sel=2 shows first=0xDEADBEEF; EN_deq -> intr_channel=0, intr_status=0 one cycle later.
REQ-020 Full/drop: DEPTH=4; 5 back-to-back enqueues on channel 0 -> RDY_ind[0]=0 after the 4th, drop_count=1, dequeued order is words 1..4.
REQ-021 Round robin: channels 0, 1, 3 each hold one word; the host always dequeues the channel reported in intr_channel -> observed order is channels 0, 1, 3, then intr_channel=0.
REQ-022 Concurrency: channel 1 holding 2 words gets enqueue and dequeue in the same cycle -> count stays 2, FIFO order preserved; with intr_enable=0, intr_status=0 while intr_channel=2.
REQ-023 Size and reset: methodNumber=3 -> size=32, methodNumber=4 -> size=0; assert RST with 3 words queued -> all outputs return to their REQ-017 values immediately, without waiting for a clock edge.
